chain_decoder: RTL

- Reconstructs a 64x64 binary boundary image from an 8-direction Freeman chain code stream.
- The stream is the one produced by the team's chain-code encoder: start pixel, perimeter count, then one code per step.
- Marks every visited boundary pixel in an internal 64x64 bitmap, checks that the chain closes on the start pixel, then streams the bitmap out one 64-bit row per cycle.
- Used as the loop-back checker for the encoder and as the image rebuild stage on the receive side.

---
 rtl/chain_decoder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/chain_decoder.sv
// chain_decoder: rebuilds a DIM x DIM boundary bitmap from a Freeman chain code stream,
// checks that the chain closes on its start pixel, then streams the bitmap out row by row.
//   clk, reset (async, active-high)
//   start/start_x/start_y/perimeter : run request, taken in IDLE or DONE
//   code_in/code_valid/code_ready   : chain code handshake, one code per accepted cycle
//   row_data/row_idx/row_valid      : bitmap dump, bit DIM-1 = column 0
//   busy, done, error               : run status; error is valid while done=1
module chain_decoder #(
    parameter int DIM     = 64,
    parameter int PERIM_W = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [$clog2(DIM)-1:0]  start_x,
    input  logic [$clog2(DIM)-1:0]  start_y,
    input  logic [PERIM_W-1:0]      perimeter,
    input  logic [7:0]              code_in,
    input  logic                    code_valid,
    output logic                    code_ready,
    output logic [DIM-1:0]          row_data,
    output logic [$clog2(DIM)-1:0]  row_idx,
    output logic                    row_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);
    localparam int AW = $clog2(DIM);
    typedef enum logic [2:0] {IDLE, CLEAR, DECODE, CHECK, DUMP, DONE} state_t;
    state_t state, state_nx;
    logic [AW-1:0] sx, sy, ci, cj, ni, nj, r;
    logic [PERIM_W-1:0] perim, count;
    logic err_wrap, err_code;
    logic [DIM-1:0] bitmap [DIM];
    logic up, down, left, right, wrap, take, last_row, go;
    assign go       = start && (state == IDLE || state == DONE);
    assign last_row = r == AW'(DIM - 1);
    assign take     = code_valid && code_ready;
    assign up       = code_in[2:0] inside {3'd1, 3'd2, 3'd3};
    assign down     = code_in[2:0] inside {3'd5, 3'd6, 3'd7};
    assign right    = code_in[2:0] inside {3'd0, 3'd1, 3'd7};
    assign left     = code_in[2:0] inside {3'd3, 3'd4, 3'd5};
    assign ni       = down ? ci + 1'b1 : up ? ci - 1'b1 : ci;
    assign nj       = right ? cj + 1'b1 : left ? cj - 1'b1 : cj;
    assign wrap     = (down && ci == '1) || (up && ci == '0) || (right && cj == '1) || (left && cj == '0);
    // code_ready falls once the last code has been counted, one cycle before leaving DECODE
    assign code_ready = state == DECODE && count != perim;
    assign busy       = state != IDLE && state != DONE;
    assign done       = state == DONE;
    assign row_valid  = state == DUMP;
    assign row_idx    = row_valid ? r : '0;
    assign row_data   = row_valid ? bitmap[r] : '0;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = go ? CLEAR : state;
            CLEAR:      state_nx = last_row ? (perim == '0 ? CHECK : DECODE) : CLEAR;
            DECODE:     state_nx = count == perim ? CHECK : DECODE;
            CHECK:      state_nx = DUMP;
            DUMP:       state_nx = last_row ? DONE : DUMP;
            default:    state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            r        <= '0;
            sx       <= '0;
            sy       <= '0;
            perim    <= '0;
            ci       <= '0;
            cj       <= '0;
            count    <= '0;
            err_wrap <= 1'b0;
            err_code <= 1'b0;
            error    <= 1'b0;
        end else begin
            state <= state_nx;
            if (go) begin
                sx       <= start_x;
                sy       <= start_y;
                perim    <= perimeter;
                r        <= '0;
                err_wrap <= 1'b0;
                err_code <= 1'b0;
                error    <= 1'b0;
            end
            if (state == CLEAR) begin
                r <= r + 1'b1;
                if (last_row) begin
                    ci    <= sx;
                    cj    <= sy;
                    count <= '0;
                end
            end
            if (state == DECODE && take) begin
                ci       <= ni;
                cj       <= nj;
                count    <= count + 1'b1;
                err_wrap <= err_wrap | wrap;
                err_code <= err_code | (|code_in[7:3]);
            end
            if (state == CHECK) begin
                error <= (ci != sx || cj != sy) || err_wrap || err_code;
                r     <= '0;
            end
            if (state == DUMP) r <= r + 1'b1;
        end
    end
    // Bitmap needs no reset: CLEAR rewrites every row at the start of each run.
    // Column j lives at bit DIM-1-j, i.e. ~j for a power-of-two DIM.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            bitmap[r] <= '0;
            if (last_row) bitmap[sx][~sy] <= 1'b1;
        end else if (state == DECODE && take) begin
            bitmap[ni][~nj] <= 1'b1;
        end
    end
endmodule
